nic_pe_port: RTL and testbench
==============================

NIC_PE_PORT -- requirements
Module: nic_pe_port

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the packet and the processor data bus.
REQ-002 Parameter VC_BIT, default 63, index of the virtual-channel bit within a packet.
REQ-003 The ports SHALL be as follows; clock is clk and reset is reset, one clock, reset synchronous active-high.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- addr  input  2  processor register select.
- d_in  input  DATA_WIDTH  processor write data.
- d_out  output  DATA_WIDTH  processor read data, registered.
- nicEn  input  1  processor access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  send-out to the router PE input; drives router pesi.
- net_ro  input  1  router ready; driven by router peri.
- net_do  output  DATA_WIDTH  packet to the router; drives router pedi.
- net_polarity  input  1  router polarity, toggles every cycle.
- net_si  input  1  router eject valid; driven by router peso.
- net_ri  output  1  NIC ready to accept an ejected packet; drives router pero.
- net_di  input  DATA_WIDTH  ejected packet; driven by router pedo.

Function
REQ-004 The NIC SHALL hold one output buffer (out_buf, out_full) and one input buffer (in_buf, in_full).
REQ-005 Register map: addr 00 = read in_buf; addr 01 = read in_full status; addr 10 = write out_buf; addr 11 = read out_full status.
REQ-006 A write SHALL occur at the edge where nicEn=1, nicWrEn=1, addr=10 and out_full=0: out_buf<=d_in and out_full<=1.
REQ-007 A write to addr 10 while out_full=1 SHALL be discarded with no state change.
REQ-008 Writes to addr 00, 01 or 11 SHALL be ignored.
REQ-009 A read (nicEn=1, nicWrEn=0) SHALL update d_out at the next edge, giving 1-cycle read latency.
- addr 00 returns in_buf.
- addr 01 returns zero-extended in_full.
- addr 11 returns zero-extended out_full.
- addr 10 returns 0.
REQ-010 d_out SHALL hold its value in cycles with no read.
REQ-011 A read of addr 00 while in_full=1 SHALL clear in_full at the same edge that loads d_out.
REQ-012 A read of addr 00 while in_full=0 SHALL return the stale in_buf and change no state.
REQ-013 Output channel handshake:
- net_do = out_buf, combinational.
- net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity), combinational.
REQ-014 At an edge where net_so=1, out_full SHALL clear; the packet is transferred exactly once.
REQ-015 When out_buf[VC_BIT] != net_polarity, net_so SHALL stay 0 for that cycle, so transmission waits for the matching polarity.
REQ-016 A processor write at the same edge as a send SHALL be discarded, because out_full=1 at that edge; software re-polls addr 11.
REQ-017 Input channel handshake:
- net_ri = ~in_full & ~reset.
- At an edge where net_si & net_ri: in_buf<=net_di and in_full<=1.
REQ-018 When net_si=1 and in_full=1, the NIC SHALL not capture, and in_buf SHALL be preserved.
REQ-019 A read of addr 00 clearing in_full SHALL raise net_ri in the next cycle, never in the same cycle, giving a 1-cycle bubble.
REQ-020 The input and output channels SHALL operate independently and concurrently.
REQ-021 The NIC SHALL not inspect or modify packet fields other than VC_BIT.

Reset
REQ-022 While reset=1 at an edge, the following SHALL be cleared:
- out_full<=0, in_full<=0.
- out_buf<=0, in_buf<=0.
- d_out<=0.
REQ-023 While reset=1, net_so=0 and net_ri=0.
REQ-024 A reset asserted mid-operation SHALL drop any buffered packet without transmitting it.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset: hold reset 2 cycles -> d_out=0, net_so=0, net_ri=0; one cycle after release net_ri=1, status reads of 01 and 11 return 0.
- Transmit with polarity gating: write addr10 = C000_0000_1111_1111 (VC=1), net_ro=1 -> net_so=1 only in cycles with net_polarity=1, net_do matches the written word, out_full=0 the following cycle, the transfer happens exactly once.
- Back-pressure: net_ro=0 for 5 cycles after a write -> net_so stays 0; after net_ro=1 and matching polarity, the packet is sent once; a second write during the hold is discarded (addr 11 reads 1, then the original data is sent).
- Receive: net_si=1, net_di=8000_0000_2222_2222 -> net_ri=0 next cycle; read addr01 -> d_out=1; read addr00 -> d_out=8000_0000_2222_2222 one cycle later; net_ri=1 the cycle after the read edge.
- Input full: second net_si with data 3333 while in_full=1 -> not captured, the addr00 read returns 2222 data.
- Concurrency and reset: simultaneous send and receive in one cycle both complete; assert reset with both buffers full -> net_so=0 and both status reads return 0 afterward.

Source files
------------

// File: rtl/nic_pe_port.sv
// Processor-side network interface: a one-packet output buffer feeding the router PE input,
// and a one-packet input buffer filled from the router PE output, both behind a 2-bit register map.
module nic_pe_port #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [DATA_WIDTH-1:0] out_buf;
    logic [DATA_WIDTH-1:0] in_buf;
    logic                  out_full;
    logic                  in_full;

    logic proc_read;
    logic proc_write;
    logic send_now;
    logic recv_now;

    assign proc_read  = nicEn & ~nicWrEn;
    assign proc_write = nicEn & nicWrEn & (addr == ADDR_OUT_BUF) & ~out_full;

    // The router only accepts a packet whose virtual channel matches its current polarity.
    assign send_now = out_full & net_ro & (out_buf[VC_BIT] == net_polarity) & ~reset;
    assign recv_now = net_si & net_ri;

    assign net_so = send_now;
    assign net_do = out_buf;
    assign net_ri = ~in_full & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (proc_write) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end else if (send_now) begin
            out_full <= 1'b0;
        end
    end

    // Draining in_full on a data read is what opens net_ri again, one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (proc_read && (addr == ADDR_IN_BUF) && in_full) begin
            in_full <= 1'b0;
        end else if (recv_now) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (proc_read) begin
            case (addr)
                ADDR_IN_BUF:     d_out <= in_buf;
                ADDR_IN_STATUS:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STATUS: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:         d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_pe_port.sv
// Testbench for nic_pe_port: a directed vector table for the handshake corner cases,
// then randomized traffic checked against a queue-based model of the two buffers.
module tb_nic_pe_port;

    localparam int DW = 64;
    localparam int VC = 63;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_polarity;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;

    int checks = 0;
    int errors = 0;

    nic_pe_port #(.DATA_WIDTH(DW), .VC_BIT(VC)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          en;
        logic          wr;
        logic [1:0]    addr;
        logic [DW-1:0] din;
        logic          ro;
        logic          pol;
        logic          si;
        logic [DW-1:0] di;
        logic          exp_so;
        logic          exp_ri;
        logic [DW-1:0] exp_do;
        logic [DW-1:0] exp_dout;
    } vec_t;

    function automatic vec_t mk(input logic rst, en, wr, input logic [1:0] a, input logic [DW-1:0] din,
                                input logic ro, pol, si, input logic [DW-1:0] di,
                                input logic so, ri, input logic [DW-1:0] ndo, dout);
        vec_t v;
        v.rst = rst; v.en = en; v.wr = wr; v.addr = a; v.din = din;
        v.ro = ro; v.pol = pol; v.si = si; v.di = di;
        v.exp_so = so; v.exp_ri = ri; v.exp_do = ndo; v.exp_dout = dout;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle from just after a falling edge, checks the combinational outputs,
    // then checks the registered read data just after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        reset = v.rst; nicEn = v.en; nicWrEn = v.wr; addr = v.addr; d_in = v.din;
        net_ro = v.ro; net_polarity = v.pol; net_si = v.si; net_di = v.di;
        #1;
        checkOutput({tag, " net_so"}, {{(DW-1){1'b0}}, net_so}, {{(DW-1){1'b0}}, v.exp_so});
        checkOutput({tag, " net_ri"}, {{(DW-1){1'b0}}, net_ri}, {{(DW-1){1'b0}}, v.exp_ri});
        checkOutput({tag, " net_do"}, net_do, v.exp_do);
        @(posedge clk);
        #1;
        checkOutput({tag, " d_out"}, d_out, v.exp_dout);
        @(negedge clk);
    endtask

    localparam logic [DW-1:0] PA = 64'hC000_0000_1111_1111;
    localparam logic [DW-1:0] PB = 64'h8000_0000_2222_2222;
    localparam logic [DW-1:0] PC = 64'h8000_0000_0000_3333;
    localparam logic [DW-1:0] PW = 64'h4000_0000_5555_5555;
    localparam logic [DW-1:0] Z  = '0;
    localparam logic [DW-1:0] O  = 64'd1;

    vec_t tbl[36];

    // Queue-based reference: a non-empty queue is a full buffer.
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] m_out_buf, m_in_buf, m_dout;

    initial begin
        reset = 1'b1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
        net_ro = 0; net_polarity = 0; net_si = 0; net_di = 0;
        @(posedge clk);
        @(negedge clk);

        //           rst en wr addr  din ro pol si di    so ri net_do dout
        tbl[0]  = mk(1, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 0, Z,  Z);
        tbl[1]  = mk(1, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 0, Z,  Z);
        tbl[2]  = mk(0, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 1, Z,  Z);
        tbl[3]  = mk(0, 1, 0, 2'd1, Z,  0, 0, 0, Z,   0, 1, Z,  Z);
        tbl[4]  = mk(0, 1, 0, 2'd3, Z,  0, 0, 0, Z,   0, 1, Z,  Z);
        tbl[5]  = mk(0, 1, 1, 2'd2, PA, 1, 0, 0, Z,   0, 1, Z,  Z);
        tbl[6]  = mk(0, 0, 0, 2'd0, Z,  1, 0, 0, Z,   0, 1, PA, Z);
        tbl[7]  = mk(0, 1, 0, 2'd3, Z,  1, 0, 0, Z,   0, 1, PA, O);
        tbl[8]  = mk(0, 0, 0, 2'd0, Z,  1, 1, 0, Z,   1, 1, PA, O);
        tbl[9]  = mk(0, 0, 0, 2'd0, Z,  1, 1, 0, Z,   0, 1, PA, O);
        tbl[10] = mk(0, 1, 0, 2'd3, Z,  1, 0, 0, Z,   0, 1, PA, Z);
        tbl[11] = mk(0, 1, 1, 2'd2, PW, 0, 0, 0, Z,   0, 1, PA, Z);
        tbl[12] = mk(0, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 1, PW, Z);
        tbl[13] = mk(0, 1, 1, 2'd2, PA, 0, 1, 0, Z,   0, 1, PW, Z);
        tbl[14] = mk(0, 1, 0, 2'd3, Z,  0, 0, 0, Z,   0, 1, PW, O);
        tbl[15] = mk(0, 0, 0, 2'd0, Z,  0, 1, 0, Z,   0, 1, PW, O);
        tbl[16] = mk(0, 0, 0, 2'd0, Z,  1, 1, 0, Z,   0, 1, PW, O);
        tbl[17] = mk(0, 0, 0, 2'd0, Z,  1, 0, 0, Z,   1, 1, PW, O);
        tbl[18] = mk(0, 1, 0, 2'd3, Z,  1, 0, 0, Z,   0, 1, PW, Z);
        tbl[19] = mk(0, 0, 0, 2'd0, Z,  0, 0, 1, PB,  0, 1, PW, Z);
        tbl[20] = mk(0, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 0, PW, Z);
        tbl[21] = mk(0, 1, 0, 2'd1, Z,  0, 0, 0, Z,   0, 0, PW, O);
        tbl[22] = mk(0, 0, 0, 2'd0, Z,  0, 0, 1, PC,  0, 0, PW, O);
        tbl[23] = mk(0, 1, 0, 2'd0, Z,  0, 0, 0, Z,   0, 0, PW, PB);
        tbl[24] = mk(0, 0, 0, 2'd0, Z,  0, 0, 0, Z,   0, 1, PW, PB);
        tbl[25] = mk(0, 1, 0, 2'd0, Z,  0, 0, 0, Z,   0, 1, PW, PB);
        tbl[26] = mk(0, 1, 1, 2'd0, PC, 0, 0, 0, Z,   0, 1, PW, PB);
        tbl[27] = mk(0, 1, 0, 2'd2, Z,  0, 0, 0, Z,   0, 1, PW, Z);
        tbl[28] = mk(0, 1, 0, 2'd3, Z,  0, 0, 0, Z,   0, 1, PW, Z);
        tbl[29] = mk(0, 1, 1, 2'd2, PA, 0, 0, 0, Z,   0, 1, PW, Z);
        tbl[30] = mk(0, 0, 0, 2'd0, Z,  1, 1, 1, PC,  1, 1, PA, Z);
        tbl[31] = mk(0, 1, 0, 2'd0, Z,  0, 0, 0, Z,   0, 0, PA, PC);
        tbl[32] = mk(0, 1, 1, 2'd2, PA, 0, 0, 1, PB,  0, 1, PA, PC);
        tbl[33] = mk(1, 0, 0, 2'd0, Z,  1, 1, 0, Z,   0, 0, PA, Z);
        tbl[34] = mk(0, 1, 0, 2'd1, Z,  1, 1, 0, Z,   0, 1, Z,  Z);
        tbl[35] = mk(0, 1, 0, 2'd3, Z,  1, 1, 0, Z,   0, 1, Z,  Z);

        for (int i = 0; i < 36; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Randomized traffic; the first cycle is a reset so the model starts in step with the DUT.
        out_q.delete(); in_q.delete();
        m_out_buf = '0; m_in_buf = '0; m_dout = '0;
        for (int c = 0; c < 400; c++) begin
            vec_t v;
            logic pre_out_full, pre_in_full;
            v.rst  = (c == 0) || ($urandom_range(0, 63) == 0);
            v.en   = $urandom_range(0, 1);
            v.wr   = $urandom_range(0, 1);
            v.addr = 2'($urandom_range(0, 3));
            v.din  = {$urandom, $urandom};
            v.ro   = ($urandom_range(0, 3) != 0);
            v.pol  = c[0];
            v.si   = $urandom_range(0, 1);
            v.di   = {$urandom, $urandom};

            pre_out_full = (out_q.size() != 0);
            pre_in_full  = (in_q.size() != 0);
            v.exp_so = !v.rst && pre_out_full && v.ro && (out_q[0][VC] == v.pol);
            v.exp_ri = !v.rst && !pre_in_full;
            v.exp_do = m_out_buf;

            if (v.rst) begin
                out_q.delete(); in_q.delete();
                m_out_buf = '0; m_in_buf = '0; m_dout = '0;
            end else begin
                if (v.en && !v.wr) begin
                    case (v.addr)
                        2'd0: begin
                            m_dout = m_in_buf;
                            if (pre_in_full) void'(in_q.pop_front());
                        end
                        2'd1: m_dout = pre_in_full ? O : Z;
                        2'd3: m_dout = pre_out_full ? O : Z;
                        default: m_dout = Z;
                    endcase
                end
                if (v.exp_so) void'(out_q.pop_front());
                if (v.en && v.wr && v.addr == 2'd2 && !pre_out_full) begin
                    out_q.push_back(v.din);
                    m_out_buf = v.din;
                end
                if (v.si && !pre_in_full) begin
                    in_q.push_back(v.di);
                    m_in_buf = v.di;
                end
            end
            v.exp_dout = m_dout;
            applyStimulus(v, $sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
